scramble_tx: RTL and testbench

- Multiplicative (self-synchronising) scrambler for the transmit end of the 10-bit-per-clock word link.
- Emits one scrambled word every clock, continuously, so the far-end descrambler shifts in lockstep.
- Generator is 1 + x^4 + x^23, bitwise s[t] = d[t] ^ s[t-4] ^ s[t-23].
- Accepts plaintext words over a valid/ready handshake, inserts scrambled idle words when no data is offered, and sends a post-reset training run so the descrambler self-synchronises before any payload.

---
 rtl/scramble_tx_if.sv | 19 +
 rtl/scramble_tx.sv | 91 +++++++++
 tb/tb_scramble_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/scramble_tx_if.sv
// Word-link transmit bundle: plaintext valid/ready input plus the registered line-side outputs.
interface scramble_tx_if;
    logic [9:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [9:0] scrambled;
    logic       scrambled_is_data;
    logic       trained;

    modport master (
        output din, din_valid,
        input  din_ready, scrambled, scrambled_is_data, trained
    );

    modport slave (
        input  din, din_valid,
        output din_ready, scrambled, scrambled_is_data, trained
    );
endinterface

// File: rtl/scramble_tx.sv
// Multiplicative 1 + x^4 + x^23 scrambler, 10 bits per tclk, with post-reset training run.
// Optional macro SCRAMBLE_TX_BYPASS_EN adds a 'bypass' input that sends plaintext unscrambled.
module scramble_tx #(
    parameter logic [22:0] SEED        = 23'd1,
    parameter logic [9:0]  IDLE_WORD   = 10'h000,
    parameter int unsigned TRAIN_WORDS = 8
) (
    input  logic tclk,
    input  logic rst,
`ifdef SCRAMBLE_TX_BYPASS_EN
    input  logic bypass,
`endif
    scramble_tx_if.slave link
);

    typedef enum logic {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_WORDS - 1);

    state_t      state_reg;
    logic [7:0]  train_cnt_reg;
    logic [22:0] hist_reg;
    logic [9:0]  scrambled_reg;
    logic        is_data_reg;
    logic        trained_reg;

    logic        fire;
    logic [9:0]  p_word;
    logic [9:0]  s_scr;
    logic [9:0]  s_next;

    // Ready depends only on state (and is held low while reset is asserted).
    assign link.din_ready = (state_reg == ST_RUN) && !rst;
    assign fire           = link.din_valid && link.din_ready;
    assign p_word         = fire ? link.din : IDLE_WORD;

    // Bits 9..6 tap only history; bits 5..0 chain on the s[i+4] computed above them.
    always_comb begin
        s_scr = '0;
        for (int i = 9; i >= 6; i--) begin
            s_scr[i] = p_word[i] ^ hist_reg[i - 6] ^ hist_reg[i + 13];
        end
        for (int i = 5; i >= 0; i--) begin
            s_scr[i] = p_word[i] ^ s_scr[i + 4] ^ hist_reg[i + 13];
        end
    end

`ifdef SCRAMBLE_TX_BYPASS_EN
    assign s_next = bypass ? p_word : s_scr;
`else
    assign s_next = s_scr;
`endif

    always_ff @(posedge tclk) begin
        if (rst) begin
            state_reg     <= ST_TRAIN;
            train_cnt_reg <= 8'd0;
            hist_reg      <= SEED;
            scrambled_reg <= 10'h000;
            is_data_reg   <= 1'b0;
            trained_reg   <= 1'b0;
        end else begin
            hist_reg      <= {hist_reg[12:0], s_next};
            scrambled_reg <= s_next;
            is_data_reg   <= fire;
            case (state_reg)
                ST_TRAIN: begin
                    train_cnt_reg <= train_cnt_reg + 8'd1;
                    if (train_cnt_reg == TRAIN_LAST) begin
                        state_reg   <= ST_RUN;
                        trained_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_reg <= ST_RUN;
                end
                default: begin
                    state_reg <= ST_TRAIN;
                end
            endcase
        end
    end

    assign link.scrambled         = scrambled_reg;
    assign link.scrambled_is_data = is_data_reg;
    assign link.trained           = trained_reg;

endmodule

// File: tb/tb_scramble_tx.sv
// Randomized bench for scramble_tx: bit-serial reference scrambler plus a loopback descrambler.
module tb_scramble_tx;

    localparam logic [22:0] SEED  = 23'd1;
    localparam logic [9:0]  IDLE  = 10'h000;
    localparam int          TRAIN = 8;

    logic tclk = 1'b0;
    logic rst  = 1'b1;
    always #5 tclk = ~tclk;

    scramble_tx_if link();

`ifdef SCRAMBLE_TX_BYPASS_EN
    logic bypass = 1'b0;
`endif

    scramble_tx #(
        .SEED(SEED),
        .IDLE_WORD(IDLE),
        .TRAIN_WORDS(TRAIN)
    ) dut (
        .tclk(tclk),
        .rst(rst),
`ifdef SCRAMBLE_TX_BYPASS_EN
        .bypass(bypass),
`endif
        .link(link)
    );

    // Line bit streams in transmit order; back() is the most recent bit.
    bit tx_q[$];
    bit rx_q[$];
    int n_edges;
    int rx_words;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        tx_q.delete();
        for (int j = 22; j >= 0; j--) tx_q.push_back(SEED[j]);
        n_edges  = 0;
        rx_words = 0;
    endtask

    // s[t] = d[t] ^ s[t-4] ^ s[t-23], one bit at a time, oldest bit (9) first.
    task automatic tx_word(input logic [9:0] p, input bit byp, output logic [9:0] w);
        bit b;
        w = '0;
        for (int i = 9; i >= 0; i--) begin
            b = byp ? p[i] : (p[i] ^ tx_q[$-3] ^ tx_q[$-22]);
            w[i] = b;
            tx_q.push_back(b);
        end
        while (tx_q.size() > 64) void'(tx_q.pop_front());
    endtask

    task automatic rx_word(input logic [9:0] s, output logic [9:0] d);
        d = '0;
        for (int i = 9; i >= 0; i--) begin
            d[i] = s[i] ^ rx_q[$-3] ^ rx_q[$-22];
            rx_q.push_back(s[i]);
        end
        while (rx_q.size() > 64) void'(rx_q.pop_front());
    endtask

    // One clock: drive inputs, check ready, then check the registered outputs after the edge.
    task automatic step(input logic r, input logic v, input logic [9:0] d, output bit fired);
        bit         exp_ready;
        bit         byp;
        logic [9:0] p;
        logic [9:0] exp_s;
        logic [9:0] dec;
        rst            = r;
        link.din_valid = v;
        link.din       = d;
        #1;
        exp_ready = !r && (n_edges >= TRAIN);
        check("din_ready", 32'(link.din_ready), 32'(exp_ready));
        fired = v && exp_ready;
        p     = fired ? d : IDLE;
`ifdef SCRAMBLE_TX_BYPASS_EN
        byp = bypass;
`else
        byp = 1'b0;
`endif
        @(posedge tclk);
        #1;
        if (r) begin
            model_reset();
            check("rst_scrambled", 32'(link.scrambled), 32'h0);
            check("rst_is_data", 32'(link.scrambled_is_data), 32'h0);
            check("rst_trained", 32'(link.trained), 32'h0);
        end else begin
            tx_word(p, byp, exp_s);
            n_edges++;
            check("scrambled", 32'(link.scrambled), 32'(exp_s));
            check("is_data", 32'(link.scrambled_is_data), 32'(fired));
            check("trained", 32'(link.trained), 32'(n_edges >= TRAIN));
            rx_word(link.scrambled, dec);
            rx_words++;
            if (byp) rx_words = 0;
            else if (rx_words >= 4) check("descrambled", 32'(dec), 32'(p));
        end
    endtask

    logic [9:0] burst [4] = '{10'h2A5, 10'h15A, 10'h3FF, 10'h000};
    bit         gaps  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        bit         f;
        bit         accepted;
        logic [9:0] w;
        int         accept_cycle;
        for (int j = 0; j < 23; j++) rx_q.push_back(1'b0);
        model_reset();
        link.din       = '0;
        link.din_valid = 1'b0;

        // Reset with a word already offered: it must be held, not consumed.
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 10'h123, f);
        accepted = 1'b0;
        accept_cycle = -1;
        for (int c = 0; c < TRAIN + 4 && !accepted; c++) begin
            step(1'b0, 1'b1, 10'h123, f);
            if (c == 0) check("first_word", 32'(link.scrambled), 32'h044);
            if (f) begin
                accepted     = 1'b1;
                accept_cycle = c;
            end
        end
        check("first_accept_cycle", 32'(accept_cycle), 32'(TRAIN));

        // Back-to-back burst, then gapped valid.
        foreach (burst[k]) step(1'b0, 1'b1, burst[k], f);
        foreach (gaps[k]) step(1'b0, gaps[k], 10'($urandom), f);

        for (int c = 0; c < 300; c++) begin
            w = 10'($urandom);
            step(1'b0, 1'($urandom_range(0, 1)), w, f);
        end

        // One-cycle reset mid-burst; the offered word must not be acknowledged.
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 10'($urandom), f);
        step(1'b1, 1'b1, 10'h2AA, f);
        check("midrst_not_acked", 32'(link.scrambled_is_data), 32'h0);
        for (int c = 0; c < 120; c++) step(1'b0, 1'($urandom_range(0, 1)), 10'($urandom), f);

`ifdef SCRAMBLE_TX_BYPASS_EN
        bypass = 1'b1;
        step(1'b0, 1'b1, 10'h155, f);
        check("bypass_word", 32'(link.scrambled), 32'h155);
        bypass = 1'b0;
        for (int c = 0; c < 20; c++) step(1'b0, 1'b1, 10'($urandom), f);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
